// File: rtl/cnna_pkg.sv
// Shared definitions for the conv engine buffer controllers: the write-side
// FSM state encoding and the address-size helper used for alignment widths.
package cnna_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_F    = 3'd2,
        ST_WAIT_BANK = 3'd3,
        ST_DRAIN     = 3'd4
    } state_e;

    // Number of address bits needed to index 'value' entries (ceil log2).
    function automatic int GETASIZE(input int value);
        int width;
        width = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width = i + 32'sd1;
            end
        end
        return width;
    endfunction

    localparam int CH_IN_DEF  = 32'sd16;
    localparam int CH_OUT_DEF = 32'sd32;
    localparam int CI_ALIGN_W = GETASIZE(CH_IN_DEF);
    localparam int CO_ALIGN_W = GETASIZE(CH_OUT_DEF);

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Tracks occupancy of the two feature banks. The writer fills banks in
// alternation (wbank), the compute side releases them in the same order
// (rbank). A release aimed at an empty bank is ignored.
module pingpong_bank_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       row_end,
    input  logic       consume,
    output logic [1:0] full,
    output logic       wbank,
    output logic       rbank
);

    logic [1:0] full_r;
    logic [1:0] full_nxt_s;
    logic       wbank_r;
    logic       wbank_nxt_s;
    logic       rbank_r;
    logic       rbank_nxt_s;

    // Next-state of flags and pointers; a release and a row end may land on
    // different banks in the same cycle and both take effect.
    always_comb begin
        full_nxt_s  = full_r;
        wbank_nxt_s = wbank_r;
        rbank_nxt_s = rbank_r;
        if (clr) begin
            full_nxt_s  = 2'b00;
            wbank_nxt_s = 1'b0;
            rbank_nxt_s = 1'b0;
        end else begin
            if (consume && full_r[rbank_r]) begin
                full_nxt_s[rbank_r] = 1'b0;
                rbank_nxt_s         = ~rbank_r;
            end else begin
                rbank_nxt_s = rbank_r;
            end
            if (row_end) begin
                full_nxt_s[wbank_r] = 1'b1;
                wbank_nxt_s         = ~wbank_r;
            end else begin
                wbank_nxt_s = wbank_r;
            end
        end
    end

    // Flag and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r  <= 2'b00;
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
        end else begin
            full_r  <= full_nxt_s;
            wbank_r <= wbank_nxt_s;
            rbank_r <= rbank_nxt_s;
        end
    end

    assign full  = full_r;
    assign wbank = wbank_r;
    assign rbank = rbank_r;

endmodule

// File: rtl/wr_addr_ctl.sv
// Write-side address controller: steers one layer's stream into the weight
// buffer and then row by row into the ping-pong feature buffer, and raises
// the load handshakes the read-address controller waits on.
module wr_addr_ctl
    import cnna_pkg::*;
#(
    parameter int AXIWIDTH   = 32,
    parameter int DEPTHWIDTH = 9,
    parameter int DWIDTH     = 256,
    parameter int CH_IN      = 16,
    parameter int CH_OUT     = 32
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_ap_start,
    input  logic [DEPTHWIDTH-1:0] I_ciGroup,
    input  logic [DEPTHWIDTH-1:0] I_wi_num,
    input  logic [DEPTHWIDTH:0]   I_w_words,
    input  logic [AXIWIDTH-1:0]   I_row_num,
    input  logic [DWIDTH-1:0]     I_data,
    input  logic                  I_data_valid,
    output logic                  O_data_ready,
    input  logic                  I_row_consumed,
    output logic [DWIDTH-1:0]     O_wr_data,
    output logic                  O_wr_wen,
    output logic [DEPTHWIDTH-1:0] O_wr_wdepth,
    output logic                  O_wr_fen,
    output logic                  O_wr_fbank,
    output logic [DEPTHWIDTH-1:0] O_wr_fdepth,
    output logic                  O_weight_load_done,
    output logic                  O_f_rdy,
    output logic                  O_layer_done
);

    localparam logic [DEPTHWIDTH-1:0] ZERO_D  = {DEPTHWIDTH{1'b0}};
    localparam logic [DEPTHWIDTH-1:0] ONE_D   = {{(DEPTHWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTHWIDTH:0]   ZERO_W  = {(DEPTHWIDTH+1){1'b0}};
    localparam logic [DEPTHWIDTH:0]   ONE_W   = {{DEPTHWIDTH{1'b0}}, 1'b1};
    localparam logic [AXIWIDTH-1:0]   ZERO_R  = {AXIWIDTH{1'b0}};
    localparam logic [AXIWIDTH-1:0]   ONE_R   = {{(AXIWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWIDTH-1:0]     ZERO_DW = {DWIDTH{1'b0}};

    // A beat must hold whole pixels of CH_IN bytes and whole weight words of CH_OUT bytes.
    if (((DWIDTH % (CH_IN * 8)) != 0) || ((DWIDTH % (CH_OUT * 8)) != 0)) begin : g_bad_packing
        $error("wr_addr_ctl: DWIDTH does not pack CH_IN/CH_OUT byte lanes evenly");
    end

    // Start edge detection and layer configuration
    logic                  start_d1_r;
    logic                  start_d2_r;
    logic                  start_edge_s;
    logic [DEPTHWIDTH-1:0] ci_group_r;
    logic [DEPTHWIDTH-1:0] wi_num_r;
    logic [DEPTHWIDTH:0]   w_words_r;
    logic [AXIWIDTH-1:0]   row_num_r;

    // FSM and counters
    state_e                state_r;
    state_e                state_nxt_s;
    logic [DEPTHWIDTH-1:0] wcnt_r;
    logic [DEPTHWIDTH-1:0] cig_r;
    logic [DEPTHWIDTH-1:0] pix_r;
    logic [DEPTHWIDTH-1:0] facc_r;
    logic [AXIWIDTH-1:0]   row_cnt_r;

    // Registered outputs
    logic [DWIDTH-1:0]     wr_data_r;
    logic                  wen_r;
    logic [DEPTHWIDTH-1:0] wdepth_r;
    logic                  fen_r;
    logic                  fbank_r;
    logic [DEPTHWIDTH-1:0] fdepth_r;
    logic                  weight_done_r;
    logic                  f_rdy_r;
    logic                  layer_done_r;

    // Decoded conditions
    logic       ready_s;
    logic       w_accept_s;
    logic       f_accept_s;
    logic       drain_empty_s;
    logic       w_last_s;
    logic       cig_last_s;
    logic       pix_last_s;
    logic       row_end_s;
    logic       row_last_s;
    logic       other_busy_s;
    logic       start_to_f_s;
    logic [1:0] full_s;
    logic       wbank_s;
    logic       rbank_s;

    assign start_edge_s = start_d1_r & ~start_d2_r;
    assign start_to_f_s = (I_w_words == ZERO_W);
    assign w_last_s     = (({1'b0, wcnt_r} + ONE_W) == w_words_r);
    assign cig_last_s   = ((cig_r + ONE_D) == ci_group_r);
    assign pix_last_s   = ((pix_r + ONE_D) == wi_num_r);
    assign row_end_s    = f_accept_s & cig_last_s & pix_last_s;
    assign row_last_s   = ((row_cnt_r + ONE_R) == row_num_r);
    // The bank after this one stays busy unless it is being released right now.
    assign other_busy_s = full_s[~wbank_s] & ~(I_row_consumed & (rbank_s != wbank_s));

    pingpong_bank_tracker u_banks (
        .clk     (I_clk),
        .rst     (I_rst),
        .clr     (start_edge_s),
        .row_end (row_end_s),
        .consume (I_row_consumed),
        .full    (full_s),
        .wbank   (wbank_s),
        .rbank   (rbank_s)
    );

    // Two-stage registration of ap_start for edge detection.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            start_d1_r <= 1'b0;
            start_d2_r <= 1'b0;
        end else begin
            start_d1_r <= I_ap_start;
            start_d2_r <= start_d1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; a start edge (re)starts the layer from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (start_edge_s) begin
            state_nxt_s = start_to_f_s ? ST_LOAD_F : ST_LOAD_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_LOAD_W: begin
                    if (w_accept_s && w_last_s) begin
                        state_nxt_s = ST_LOAD_F;
                    end else begin
                        state_nxt_s = ST_LOAD_W;
                    end
                end
                ST_LOAD_F: begin
                    if (!row_end_s) begin
                        state_nxt_s = ST_LOAD_F;
                    end else if (row_last_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else if (other_busy_s) begin
                        state_nxt_s = ST_WAIT_BANK;
                    end else begin
                        state_nxt_s = ST_LOAD_F;
                    end
                end
                ST_WAIT_BANK: begin
                    if (!full_s[wbank_s]) begin
                        state_nxt_s = ST_LOAD_F;
                    end else begin
                        state_nxt_s = ST_WAIT_BANK;
                    end
                end
                ST_DRAIN: begin
                    if (full_s == 2'b00) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: ready never depends on valid, and is held low on a start edge
    // so no beat slips into the aborted layer.
    always_comb begin
        ready_s       = 1'b0;
        w_accept_s    = 1'b0;
        f_accept_s    = 1'b0;
        drain_empty_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b0;
            end
            ST_LOAD_W: begin
                ready_s    = ~start_edge_s;
                w_accept_s = ready_s & I_data_valid;
            end
            ST_LOAD_F: begin
                ready_s    = ~start_edge_s & ~full_s[wbank_s];
                f_accept_s = ready_s & I_data_valid;
            end
            ST_WAIT_BANK: begin
                ready_s = 1'b0;
            end
            ST_DRAIN: begin
                ready_s       = 1'b0;
                drain_empty_s = ~start_edge_s & (full_s == 2'b00);
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Counters, layer configuration and registered write-port outputs.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            ci_group_r    <= ZERO_D;
            wi_num_r      <= ZERO_D;
            w_words_r     <= ZERO_W;
            row_num_r     <= ZERO_R;
            wcnt_r        <= ZERO_D;
            cig_r         <= ZERO_D;
            pix_r         <= ZERO_D;
            facc_r        <= ZERO_D;
            row_cnt_r     <= ZERO_R;
            wr_data_r     <= ZERO_DW;
            wen_r         <= 1'b0;
            wdepth_r      <= ZERO_D;
            fen_r         <= 1'b0;
            fbank_r       <= 1'b0;
            fdepth_r      <= ZERO_D;
            weight_done_r <= 1'b0;
            f_rdy_r       <= 1'b0;
            layer_done_r  <= 1'b0;
        end else if (start_edge_s) begin
            ci_group_r    <= I_ciGroup;
            wi_num_r      <= I_wi_num;
            w_words_r     <= I_w_words;
            row_num_r     <= I_row_num;
            wcnt_r        <= ZERO_D;
            cig_r         <= ZERO_D;
            pix_r         <= ZERO_D;
            facc_r        <= ZERO_D;
            row_cnt_r     <= ZERO_R;
            wen_r         <= 1'b0;
            fen_r         <= 1'b0;
            f_rdy_r       <= 1'b0;
            layer_done_r  <= 1'b0;
            // A layer without weights is immediately weight-complete.
            weight_done_r <= start_to_f_s;
        end else begin
            wen_r        <= 1'b0;
            fen_r        <= 1'b0;
            f_rdy_r      <= 1'b0;
            layer_done_r <= drain_empty_s;
            if (w_accept_s || f_accept_s) begin
                wr_data_r <= I_data;
            end
            if (w_accept_s) begin
                wen_r    <= 1'b1;
                wdepth_r <= wcnt_r;
                wcnt_r   <= wcnt_r + ONE_D;
                if (w_last_s) begin
                    weight_done_r <= 1'b1;
                end
            end
            if (f_accept_s) begin
                fen_r    <= 1'b1;
                fbank_r  <= wbank_s;
                fdepth_r <= facc_r;
                // facc tracks pix*ciGroup+cig by stepping once per beat.
                if (!cig_last_s) begin
                    cig_r  <= cig_r + ONE_D;
                    facc_r <= facc_r + ONE_D;
                end else if (!pix_last_s) begin
                    cig_r  <= ZERO_D;
                    pix_r  <= pix_r + ONE_D;
                    facc_r <= facc_r + ONE_D;
                end else begin
                    cig_r     <= ZERO_D;
                    pix_r     <= ZERO_D;
                    facc_r    <= ZERO_D;
                    row_cnt_r <= row_cnt_r + ONE_R;
                    f_rdy_r   <= 1'b1;
                end
            end
        end
    end

    assign O_data_ready       = ready_s;
    assign O_wr_data          = wr_data_r;
    assign O_wr_wen           = wen_r;
    assign O_wr_wdepth        = wdepth_r;
    assign O_wr_fen           = fen_r;
    assign O_wr_fbank         = fbank_r;
    assign O_wr_fdepth        = fdepth_r;
    assign O_weight_load_done = weight_done_r;
    assign O_f_rdy            = f_rdy_r;
    assign O_layer_done       = layer_done_r;

endmodule

// File: tb/tb_wr_addr_ctl.sv
// Directed bench for wr_addr_ctl: a per-cycle vector table for a full layer
// (weights, two rows, drain, release) plus hand-written corner sequences.
module tb_wr_addr_ctl;

    logic         I_clk = 1'b0;
    logic         I_rst;
    logic         I_ap_start;
    logic [8:0]   I_ciGroup;
    logic [8:0]   I_wi_num;
    logic [9:0]   I_w_words;
    logic [31:0]  I_row_num;
    logic [255:0] I_data;
    logic         I_data_valid;
    logic         O_data_ready;
    logic         I_row_consumed;
    logic [255:0] O_wr_data;
    logic         O_wr_wen;
    logic [8:0]   O_wr_wdepth;
    logic         O_wr_fen;
    logic         O_wr_fbank;
    logic [8:0]   O_wr_fdepth;
    logic         O_weight_load_done;
    logic         O_f_rdy;
    logic         O_layer_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic ready_seen;

    wr_addr_ctl dut (
        .I_clk              (I_clk),
        .I_rst              (I_rst),
        .I_ap_start         (I_ap_start),
        .I_ciGroup          (I_ciGroup),
        .I_wi_num           (I_wi_num),
        .I_w_words          (I_w_words),
        .I_row_num          (I_row_num),
        .I_data             (I_data),
        .I_data_valid       (I_data_valid),
        .O_data_ready       (O_data_ready),
        .I_row_consumed     (I_row_consumed),
        .O_wr_data          (O_wr_data),
        .O_wr_wen           (O_wr_wen),
        .O_wr_wdepth        (O_wr_wdepth),
        .O_wr_fen           (O_wr_fen),
        .O_wr_fbank         (O_wr_fbank),
        .O_wr_fdepth        (O_wr_fdepth),
        .O_weight_load_done (O_weight_load_done),
        .O_f_rdy            (O_f_rdy),
        .O_layer_done       (O_layer_done)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        bit st;
        bit v;
        bit cons;
        bit e_ready;
        bit e_wen;
        int e_wdepth;
        bit e_fen;
        bit e_fbank;
        int e_fdepth;
        bit e_done;
        bit e_frdy;
        bit e_ldone;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [255:0] pat(input int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ k;
        return {8{w}};
    endfunction

    function automatic vec_t mk(input bit st, input bit v, input bit cons, input bit rdy,
                                input bit wen, input int wd, input bit fen, input bit fb,
                                input int fd, input bit done, input bit frdy, input bit ld);
        vec_t t;
        t.st = st; t.v = v; t.cons = cons; t.e_ready = rdy;
        t.e_wen = wen; t.e_wdepth = wd; t.e_fen = fen; t.e_fbank = fb;
        t.e_fdepth = fd; t.e_done = done; t.e_frdy = frdy; t.e_ldone = ld;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample ready mid-cycle, return #1 after the edge.
    task automatic step(input bit st, input bit v, input bit cons, input int k);
        I_ap_start     = st;
        I_data_valid   = v;
        I_row_consumed = cons;
        I_data         = pat(k);
        #4;
        ready_seen = O_data_ready;
        @(posedge I_clk);
        #1;
    endtask

    task automatic do_reset();
        I_rst          = 1'b1;
        I_ap_start     = 1'b0;
        I_data_valid   = 1'b0;
        I_row_consumed = 1'b0;
        I_data         = 256'd0;
        repeat (2) @(posedge I_clk);
        #1;
        I_rst = 1'b0;
    endtask

    task automatic cfg(input int cig, input int wi, input int ww, input int rows);
        I_ciGroup = cig[8:0];
        I_wi_num  = wi[8:0];
        I_w_words = ww[9:0];
        I_row_num = rows;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, O_data_ready, 1'b0);
        chk({tag, "_wen"}, O_wr_wen, 1'b0);
        chk({tag, "_wdepth"}, O_wr_wdepth, 9'd0);
        chk({tag, "_fen"}, O_wr_fen, 1'b0);
        chk({tag, "_fbank"}, O_wr_fbank, 1'b0);
        chk({tag, "_fdepth"}, O_wr_fdepth, 9'd0);
        chk({tag, "_data"}, O_wr_data, 256'd0);
        chk({tag, "_done"}, O_weight_load_done, 1'b0);
        chk({tag, "_frdy"}, O_f_rdy, 1'b0);
        chk({tag, "_ldone"}, O_layer_done, 1'b0);
    endtask

    initial begin
        int n;
        bit v;
        int m;

        cfg(2, 3, 4, 2);
        do_reset();
        chk_zero("reset");

        // Layer table: 2 start-detect cycles, 4 weights, 2 rows of 6 beats,
        // drain idle, two separated releases, layer_done, idle.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 1, 0, 1, 1, i, 0, 0, 0, (i == 3), 0, 0));
        end
        for (int j = 0; j < 12; j++) begin
            tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, (j / 6), (j % 6), 1, ((j % 6) == 5), 0));
        end
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            vec_t t;
            t = tbl[k];
            step(t.st, t.v, t.cons, k);
            chk($sformatf("t1_ready[%0d]", k), ready_seen, t.e_ready);
            chk($sformatf("t1_wen[%0d]", k), O_wr_wen, t.e_wen);
            chk($sformatf("t1_fen[%0d]", k), O_wr_fen, t.e_fen);
            chk($sformatf("t1_done[%0d]", k), O_weight_load_done, t.e_done);
            chk($sformatf("t1_frdy[%0d]", k), O_f_rdy, t.e_frdy);
            chk($sformatf("t1_ldone[%0d]", k), O_layer_done, t.e_ldone);
            if (t.e_wen) begin
                chk($sformatf("t1_wdepth[%0d]", k), O_wr_wdepth, t.e_wdepth[8:0]);
                chk($sformatf("t1_wdata[%0d]", k), O_wr_data, pat(k));
            end
            if (t.e_fen) begin
                chk($sformatf("t1_fbank[%0d]", k), O_wr_fbank, t.e_fbank);
                chk($sformatf("t1_fdepth[%0d]", k), O_wr_fdepth, t.e_fdepth[8:0]);
                chk($sformatf("t1_fdata[%0d]", k), O_wr_data, pat(k));
            end
        end

        // Three rows: the third row must wait for the first bank to be released.
        do_reset();
        cfg(2, 3, 4, 3);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("t3_start_ready", ready_seen, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 100 + i);
            chk("t3_wen", O_wr_wen, 1'b1);
            chk("t3_wdepth", O_wr_wdepth, i[8:0]);
        end
        for (int j = 0; j < 12; j++) begin
            step(1, 1, 0, 200 + j);
            chk("t3_fen", O_wr_fen, 1'b1);
            chk("t3_fbank", O_wr_fbank, (j >= 6));
            m = j % 6;
            chk("t3_fdepth", O_wr_fdepth, m[8:0]);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 300);
            chk("t3_wait_ready", ready_seen, 1'b0);
            chk("t3_wait_fen", O_wr_fen, 1'b0);
        end
        step(1, 1, 1, 301);
        chk("t3_cons_ready", ready_seen, 1'b0);
        step(1, 1, 0, 302);
        chk("t3_cons1_ready", ready_seen, 1'b0);
        step(1, 1, 0, 303);
        chk("t3_cons2_ready", ready_seen, 1'b1);
        chk("t3_row2_fen", O_wr_fen, 1'b1);
        chk("t3_row2_fbank", O_wr_fbank, 1'b0);
        chk("t3_row2_fdepth0", O_wr_fdepth, 9'd0);
        chk("t3_row2_data", O_wr_data, pat(303));
        for (int j = 1; j < 6; j++) begin
            step(1, 1, 0, 310 + j);
            chk("t3_row2_fdepth", O_wr_fdepth, j[8:0]);
            chk("t3_row2_frdy", O_f_rdy, (j == 5));
        end
        step(1, 1, 0, 320);
        chk("t3_drain_ready", ready_seen, 1'b0);

        // Valid on every other cycle: write stream stays contiguous.
        do_reset();
        cfg(2, 3, 4, 2);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        n = 0;
        for (int j = 0; j < 32; j++) begin
            v = ((j % 2) == 0);
            step(1, v, 0, 400 + j);
            if (v) begin
                if (n < 4) begin
                    chk("t4_wen", O_wr_wen, 1'b1);
                    chk("t4_wdepth", O_wr_wdepth, n[8:0]);
                    chk("t4_done", O_weight_load_done, (n == 3));
                    chk("t4_fen_off", O_wr_fen, 1'b0);
                end else begin
                    m = (n - 4) % 6;
                    chk("t4_fen", O_wr_fen, 1'b1);
                    chk("t4_fbank", O_wr_fbank, ((n - 4) >= 6));
                    chk("t4_fdepth", O_wr_fdepth, m[8:0]);
                    chk("t4_wen_off", O_wr_wen, 1'b0);
                end
                chk("t4_data", O_wr_data, pat(400 + j));
                n++;
            end else begin
                chk("t4_gap_wen", O_wr_wen, 1'b0);
                chk("t4_gap_fen", O_wr_fen, 1'b0);
            end
        end

        // No weights: done before the first feature write, which lands at bank0/0.
        do_reset();
        cfg(2, 3, 0, 2);
        step(1, 1, 0, 500);
        chk("t5_done_pre", O_weight_load_done, 1'b0);
        step(1, 1, 0, 501);
        chk("t5_edge_ready", ready_seen, 1'b0);
        chk("t5_done", O_weight_load_done, 1'b1);
        chk("t5_edge_fen", O_wr_fen, 1'b0);
        step(1, 1, 0, 502);
        chk("t5_fen", O_wr_fen, 1'b1);
        chk("t5_wen", O_wr_wen, 1'b0);
        chk("t5_fbank", O_wr_fbank, 1'b0);
        chk("t5_fdepth", O_wr_fdepth, 9'd0);
        chk("t5_data", O_wr_data, pat(502));

        // Restart edge during row1, then reset mid-row.
        do_reset();
        cfg(2, 3, 4, 2);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 600 + i);
        end
        chk("t6_pre_fbank", O_wr_fbank, 1'b1);
        chk("t6_pre_fdepth", O_wr_fdepth, 9'd1);
        step(0, 1, 0, 620);
        chk("t6_low_fdepth", O_wr_fdepth, 9'd2);
        step(1, 1, 0, 621);
        chk("t6_rise_fdepth", O_wr_fdepth, 9'd3);
        step(1, 1, 0, 622);
        chk("t6_edge_ready", ready_seen, 1'b0);
        chk("t6_edge_done", O_weight_load_done, 1'b0);
        chk("t6_edge_fen", O_wr_fen, 1'b0);
        chk("t6_edge_wen", O_wr_wen, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 630 + i);
            chk("t6_wen", O_wr_wen, 1'b1);
            chk("t6_wdepth", O_wr_wdepth, i[8:0]);
            chk("t6_done", O_weight_load_done, (i == 3));
        end
        step(1, 1, 0, 640);
        chk("t6_f0_fbank", O_wr_fbank, 1'b0);
        chk("t6_f0_fdepth", O_wr_fdepth, 9'd0);
        step(1, 1, 0, 641);
        chk("t6_f1_fdepth", O_wr_fdepth, 9'd1);
        I_rst = 1'b1;
        step(1, 1, 0, 642);
        chk_zero("t6_rst");
        I_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
